step_ctrl: RTL and testbench

- Front-end controller between the board push-button/mode switches and `cpu_top`'s pipeline clock-enable.
- Synchronises and debounces `button`, then generates the CPU advance strobe `cpu_ce`:
  - one single-cycle pulse per press in single-step mode;
  - continuous enable in run mode;
  - no enable when halted.
- Also exports the debounced button level and a press counter for the 7-segment/VGA debug display.

---
 rtl/cpu_ctrl_pkg.sv | 16 +
 rtl/btn_debounce.sv | 53 +++++
 rtl/step_ctrl.sv | 115 +++++++++++
 tb/tb_step_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU front-end step controller.
//   state_e        : controller FSM state, 2-bit encoded (idle/step/run = 00/01/10)
//   DbCyclesSim    : debounce length used in simulation
//   DbCyclesBoard  : debounce length used on the board build
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StStep = 2'b01,
    StRun  = 2'b10
  } state_e;

  localparam int unsigned DbCyclesSim   = 16;
  localparam int unsigned DbCyclesBoard = 500000;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a counter-based debouncer.
//   clk_i    : system clock
//   rst_i    : synchronous active-high reset
//   btn_i    : raw push-button, asynchronous to clk_i
//   level_o  : debounced button level (registered)
// The level only changes after the synchronised input has differed from it for
// DB_CYCLES consecutive cycles; any agreement in between restarts the count.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 16,
  parameter int unsigned DB_W      = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o
);

  localparam logic [DB_W-1:0] CntMax = DB_W'(DB_CYCLES - 1);

  logic            s1_q, s2_q;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      level_d = s2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/step_ctrl.sv
// Front-end controller producing the CPU pipeline clock-enable.
//   clk        : system clock
//   reset_cpu  : synchronous active-high reset
//   button     : raw push-button (asynchronous)
//   start      : 0 = halt, 1 = CPU may advance
//   enable     : with start=1, 1 = single-step, 0 = free run
//   cpu_ce     : registered CPU clock-enable
//   run_mode   : registered, 1 while in run state
//   btn_level  : registered debounced button level
//   step_count : registered count of issued single-step pulses (wraps)
module step_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DbCyclesSim,
  parameter int unsigned DB_W      = 20,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset_cpu,
  input  logic             button,
  input  logic             start,
  input  logic             enable,
  output logic             cpu_ce,
  output logic             run_mode,
  output logic             btn_level,
  output logic [CNT_W-1:0] step_count
);

  logic level;
  logic btn_q;
  logic press;

  state_e state_q, state_d;

  logic             cpu_ce_q, cpu_ce_d;
  logic             run_mode_q, run_mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) u_debounce (
    .clk_i   (clk),
    .rst_i   (reset_cpu),
    .btn_i   (button),
    .level_o (level)
  );

  // One-cycle strobe on each debounced rising edge.
  assign press = level & ~btn_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset_cpu) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start && enable)       state_d = StStep;
        else if (start && !enable) state_d = StRun;
      end
      StStep: begin
        if (!start)       state_d = StIdle;
        else if (!enable) state_d = StRun;
      end
      StRun: begin
        if (!start)      state_d = StIdle;
        else if (enable) state_d = StStep;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: enables are only issued when the state is not changing, so a
  // press coinciding with any transition is dropped and leaving run clears
  // cpu_ce on the transition edge.
  always_comb begin
    cpu_ce_d   = 1'b0;
    run_mode_d = (state_d == StRun);
    cnt_d      = cnt_q;
    if (state_q == StStep && state_d == StStep && press) begin
      cpu_ce_d = 1'b1;
      cnt_d    = cnt_q + CNT_W'(1);
    end else if (state_q == StRun && state_d == StRun) begin
      cpu_ce_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_cpu) begin
      btn_q      <= 1'b0;
      cpu_ce_q   <= 1'b0;
      run_mode_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      btn_q      <= level;
      cpu_ce_q   <= cpu_ce_d;
      run_mode_q <= run_mode_d;
      cnt_q      <= cnt_d;
    end
  end

  assign cpu_ce     = cpu_ce_q;
  assign run_mode   = run_mode_q;
  assign btn_level  = level;
  assign step_count = cnt_q;

endmodule

// File: tb/tb_step_ctrl.sv
module tb_step_ctrl;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset_cpu;
  logic             button;
  logic             start;
  logic             enable;
  logic             cpu_ce;
  logic             run_mode;
  logic             btn_level;
  logic [CNT_W-1:0] step_count;

  int checks = 0;
  int errors = 0;

  step_ctrl #(
    .DB_CYCLES (16),
    .DB_W      (20),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_cpu  (reset_cpu),
    .button     (button),
    .start      (start),
    .enable     (enable),
    .cpu_ce     (cpu_ce),
    .run_mode   (run_mode),
    .btn_level  (btn_level),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  // Stimulus only: hold button high then low, observing #1 after each edge.
  // first_k is the iteration (0 = right after the first edge sampling 1) where
  // cpu_ce is first seen high, or -1.
  task automatic do_press(input int hold, input int gap, output int highs,
                          output int rises, output int first_k, output int lvl_seen);
    logic prev;
    highs    = 0;
    rises    = 0;
    first_k  = -1;
    lvl_seen = 0;
    prev     = cpu_ce;
    button   = 1'b1;
    for (int k = 0; k < hold + gap; k++) begin
      if (k == hold) button = 1'b0;
      @(posedge clk);
      #1;
      if (cpu_ce === 1'b1) begin
        highs++;
        if (first_k < 0) first_k = k;
        if (prev !== 1'b1) rises++;
      end
      if (btn_level === 1'b1) lvl_seen = 1;
      prev = cpu_ce;
    end
  endtask

  task automatic test_reset;
    reset_cpu = 1'b1;
    button    = 1'b1;
    start     = 1'b1;
    enable    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({cpu_ce, run_mode, btn_level, step_count} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got ce=%b run=%b lvl=%b cnt=%0d, want all 0",
                 i, cpu_ce, run_mode, btn_level, step_count);
      end
    end
    reset_cpu = 1'b0;
    button    = 1'b0;
    begin
      int ce_seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk);
        #1;
        if (cpu_ce !== 1'b0) ce_seen++;
      end
      checks++;
      if (ce_seen != 0) begin
        errors++;
        $display("FAIL reset_no_ce: got %0d ce cycles, want 0", ce_seen);
      end
    end
  endtask

  task automatic test_glitch;
    int highs, rises, first_k, lvl;
    do_press(10, 40, highs, rises, first_k, lvl);
    checks++;
    if (lvl != 0) begin
      errors++;
      $display("FAIL glitch_level: btn_level seen high=%0d, want 0", lvl);
    end
    checks++;
    if (highs != 0) begin
      errors++;
      $display("FAIL glitch_ce: got %0d ce cycles, want 0", highs);
    end
    checks++;
    if (step_count !== 8'd0) begin
      errors++;
      $display("FAIL glitch_count: got %0d, want 0", step_count);
    end
  endtask

  task automatic test_single_step;
    int highs, rises, first_k, lvl;
    int tot_highs = 0;
    int tot_rises = 0;
    for (int p = 0; p < 10; p++) begin
      do_press(500, 500, highs, rises, first_k, lvl);
      tot_highs += highs;
      tot_rises += rises;
      if (p == 0) begin
        checks++;
        if (first_k != 18) begin
          errors++;
          $display("FAIL step_latency: first ce after edge %0d, want 18", first_k);
        end
        checks++;
        if (lvl != 1) begin
          errors++;
          $display("FAIL step_level: btn_level seen high=%0d, want 1", lvl);
        end
      end
    end
    checks++;
    if (tot_highs != 10 || tot_rises != 10) begin
      errors++;
      $display("FAIL step_pulses: got %0d high cycles / %0d pulses, want 10 / 10",
               tot_highs, tot_rises);
    end
    checks++;
    if (step_count !== 8'd10) begin
      errors++;
      $display("FAIL step_count: got %0d, want 10", step_count);
    end
    checks++;
    if (btn_level !== 1'b0) begin
      errors++;
      $display("FAIL step_release: btn_level got %b, want 0", btn_level);
    end
  endtask

  task automatic test_run_mode;
    int ce_cnt = 0;
    int rm_bad = 0;
    enable = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (run_mode !== 1'b1 || cpu_ce !== 1'b0) begin
      errors++;
      $display("FAIL run_entry: got run=%b ce=%b, want run=1 ce=0", run_mode, cpu_ce);
    end
    for (int k = 1; k <= 100; k++) begin
      if (k == 5) button = 1'b1;
      if (k == 45) button = 1'b0;
      @(posedge clk);
      #1;
      if (cpu_ce === 1'b1) ce_cnt++;
      if (run_mode !== 1'b1) rm_bad++;
    end
    checks++;
    if (ce_cnt != 100 || rm_bad != 0) begin
      errors++;
      $display("FAIL run_ce: got %0d ce cycles, %0d run_mode drops, want 100 / 0",
               ce_cnt, rm_bad);
    end
    checks++;
    if (step_count !== 8'd10) begin
      errors++;
      $display("FAIL run_count: got %0d, want 10", step_count);
    end
    enable = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (cpu_ce !== 1'b0 || run_mode !== 1'b0) begin
      errors++;
      $display("FAIL run_exit: got ce=%b run=%b, want 0 0", cpu_ce, run_mode);
    end
    begin
      int ce_seen = 0;
      for (int i = 0; i < 30; i++) begin
        @(posedge clk);
        #1;
        if (cpu_ce !== 1'b0) ce_seen++;
      end
      checks++;
      if (ce_seen != 0) begin
        errors++;
        $display("FAIL run_exit_idle: got %0d ce cycles, want 0", ce_seen);
      end
    end
  endtask

  task automatic test_halt;
    int bad = 0;
    int highs, rises, first_k, lvl;
    button = 1'b1;
    // Press strobe is sampled at edge 18; start drops just before it.
    for (int k = 0; k < 48; k++) begin
      if (k == 18) start = 1'b0;
      @(posedge clk);
      #1;
      if (cpu_ce !== 1'b0 || run_mode !== 1'b0) bad++;
    end
    button = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL halt_no_pulse: got %0d active cycles, want 0", bad);
    end
    checks++;
    if (step_count !== 8'd10) begin
      errors++;
      $display("FAIL halt_count: got %0d, want 10", step_count);
    end
    start = 1'b1;
    do_press(30, 30, highs, rises, first_k, lvl);
    checks++;
    if (highs != 1 || step_count !== 8'd11) begin
      errors++;
      $display("FAIL halt_resume: got %0d ce cycles cnt=%0d, want 1 cnt=11", highs, step_count);
    end
  endtask

  task automatic test_wrap;
    int highs, rises, first_k, lvl;
    int tot = 0;
    reset_cpu = 1'b1;
    @(posedge clk);
    #1;
    reset_cpu = 1'b0;
    start     = 1'b1;
    enable    = 1'b1;
    for (int p = 0; p < 256; p++) begin
      do_press(24, 24, highs, rises, first_k, lvl);
      tot += highs;
    end
    checks++;
    if (tot != 256 || step_count !== 8'd0) begin
      errors++;
      $display("FAIL wrap_256: got %0d pulses cnt=%0d, want 256 cnt=0", tot, step_count);
    end
    do_press(24, 24, highs, rises, first_k, lvl);
    checks++;
    if (highs != 1 || step_count !== 8'd1) begin
      errors++;
      $display("FAIL wrap_257: got %0d pulses cnt=%0d, want 1 cnt=1", highs, step_count);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_single_step();
    test_run_mode();
    test_halt();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
